// File: rtl/pong_pkg.sv
// Shared types and helpers for the pong match sequencer.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents: match state enum, BCD helpers, ball speed constants.
package pong_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam int           SPEED_W   = 2;
    localparam logic [SPEED_W-1:0] MIN_SPEED = 2'd1;

    // Two-digit BCD increment; callers guarantee the value never passes 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Binary to two-digit BCD, used on parameters at elaboration time.
    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

endpackage

// File: rtl/pong_frame_timer.sv
// Loadable frame down-counter; o_done flags the tick that lands on zero.
// Latency: load visible next cycle; o_done is combinational from i_tick.
// Backpressure: none; ticks are consumed only while i_en is high.
//
// Ports: clk50/reset clock and async active-low reset; i_load/i_load_val
// reload the count (load wins over a tick); i_en gates counting; i_tick is
// the frame pulse; o_done is high for the enabled tick seen at count zero.
module pong_frame_timer #(
    parameter int W = 8
) (
    input  logic         clk50,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    input  logic         i_tick,
    output logic         o_done
);

    logic [W-1:0] r_cnt;
    logic         w_zero;

    assign w_zero = (r_cnt == '0);
    assign o_done = i_en & i_tick & w_zero;

    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && i_tick && !w_zero) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve/play/point/game-over flow, scores and ball speed.
// Latency: events and ticks act at the sampling edge; start acts two cycles after it rises.
// Backpressure: none; events outside their accepting state are dropped.
//
// Ports: clk50, reset (async active-low); frame_tick, start, miss_l, miss_r,
// hit inputs; ball_run, ball_center, serve_dir, ball_speed, score_l/score_r
// (BCD {tens,ones}), game_over, winner outputs, all registered.
module pong_match_ctrl #(
    parameter int WIN_SCORE      = 11,
    parameter int SERVE_FRAMES   = 60,
    parameter int POINT_FRAMES   = 90,
    parameter int HITS_PER_LEVEL = 4,
    parameter int MAX_SPEED      = 3
) (
    input  logic       clk50,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       miss_l,
    input  logic       miss_r,
    input  logic       hit,
    output logic       ball_run,
    output logic       ball_center,
    output logic       serve_dir,
    output logic [1:0] ball_speed,
    output logic [7:0] score_l,
    output logic [7:0] score_r,
    output logic       game_over,
    output logic       winner
);

    import pong_pkg::*;

    localparam int FMAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int FW   = $clog2(FMAX + 1);
    localparam int HW   = $clog2(HITS_PER_LEVEL + 1);

    localparam logic [7:0]         WIN_BCD   = to_bcd(WIN_SCORE);
    localparam logic [FW-1:0]      SERVE_LD  = FW'(SERVE_FRAMES - 1);
    localparam logic [FW-1:0]      POINT_LD  = FW'(POINT_FRAMES - 1);
    localparam logic [HW-1:0]      HITS_LAST = HW'(HITS_PER_LEVEL - 1);
    localparam logic [SPEED_W-1:0] SPD_MAX   = SPEED_W'(MAX_SPEED);

    state_t             r_state, w_state_nxt;
    logic               r_start_q, r_start_qq;
    logic               r_run, r_center, r_dir, r_over, r_winner;
    logic [SPEED_W-1:0] r_speed;
    logic [7:0]         r_score_l, r_score_r;
    logic [HW-1:0]      r_hits;

    logic               w_center_nxt, w_dir_nxt, w_over_nxt, w_winner_nxt;
    logic [SPEED_W-1:0] w_speed_nxt;
    logic [7:0]         w_score_l_nxt, w_score_r_nxt;
    logic [HW-1:0]      w_hits_nxt;
    logic               w_start_evt;
    logic               w_tmr_load, w_tmr_en, w_tmr_done;
    logic [FW-1:0]      w_tmr_val;

    // start is first captured, then compared with its previous sample, so the
    // event is seen one cycle after the rise and acted on at the next edge.
    assign w_start_evt = r_start_q & ~r_start_qq;
    assign w_tmr_en    = (r_state == S_SERVE) || (r_state == S_POINT);

    pong_frame_timer #(.W(FW)) u_timer (
        .clk50      (clk50),
        .reset      (reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .i_tick     (frame_tick),
        .o_done     (w_tmr_done)
    );

    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_start_q  <= 1'b0;
            r_start_qq <= 1'b0;
            r_run      <= 1'b0;
            r_center   <= 1'b0;
            r_dir      <= 1'b0;
            r_over     <= 1'b0;
            r_winner   <= 1'b0;
            r_speed    <= MIN_SPEED;
            r_score_l  <= 8'h00;
            r_score_r  <= 8'h00;
            r_hits     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_start_q  <= start;
            r_start_qq <= r_start_q;
            r_run      <= (w_state_nxt == S_PLAY);
            r_center   <= w_center_nxt;
            r_dir      <= w_dir_nxt;
            r_over     <= w_over_nxt;
            r_winner   <= w_winner_nxt;
            r_speed    <= w_speed_nxt;
            r_score_l  <= w_score_l_nxt;
            r_score_r  <= w_score_r_nxt;
            r_hits     <= w_hits_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_center_nxt  = 1'b0;
        w_dir_nxt     = r_dir;
        w_over_nxt    = r_over;
        w_winner_nxt  = r_winner;
        w_speed_nxt   = r_speed;
        w_score_l_nxt = r_score_l;
        w_score_r_nxt = r_score_r;
        w_hits_nxt    = r_hits;
        w_tmr_load    = 1'b0;
        w_tmr_val     = SERVE_LD;

        case (r_state)
            S_IDLE, S_OVER: begin
                if (w_start_evt) begin
                    w_score_l_nxt = 8'h00;
                    w_score_r_nxt = 8'h00;
                    w_over_nxt    = 1'b0;
                    w_speed_nxt   = MIN_SPEED;
                    w_hits_nxt    = '0;
                    w_dir_nxt     = 1'b0;
                    w_center_nxt  = 1'b1;
                    w_tmr_load    = 1'b1;
                    w_tmr_val     = SERVE_LD;
                    w_state_nxt   = S_SERVE;
                end
            end
            S_SERVE: begin
                if (w_tmr_done) begin
                    w_state_nxt = S_PLAY;
                end
            end
            S_PLAY: begin
                // miss_l outranks miss_r, and any miss swallows a coincident hit.
                if (miss_l || miss_r) begin
                    if (miss_l) begin
                        w_score_r_nxt = bcd_inc(r_score_r);
                        w_dir_nxt     = 1'b1;
                    end else begin
                        w_score_l_nxt = bcd_inc(r_score_l);
                        w_dir_nxt     = 1'b0;
                    end
                    w_speed_nxt = MIN_SPEED;
                    w_hits_nxt  = '0;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = POINT_LD;
                    w_state_nxt = S_POINT;
                end else if (hit) begin
                    if (r_hits == HITS_LAST) begin
                        w_hits_nxt = '0;
                        if (r_speed < SPD_MAX) begin
                            w_speed_nxt = r_speed + 2'd1;
                        end
                    end else begin
                        w_hits_nxt = r_hits + HW'(1);
                    end
                end
            end
            S_POINT: begin
                if (w_tmr_done) begin
                    if ((r_score_l == WIN_BCD) || (r_score_r == WIN_BCD)) begin
                        w_over_nxt   = 1'b1;
                        w_winner_nxt = (r_score_r == WIN_BCD);
                        w_state_nxt  = S_OVER;
                    end else begin
                        w_center_nxt = 1'b1;
                        w_tmr_load   = 1'b1;
                        w_tmr_val    = SERVE_LD;
                        w_state_nxt  = S_SERVE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign ball_run    = r_run;
    assign ball_center = r_center;
    assign serve_dir   = r_dir;
    assign ball_speed  = r_speed;
    assign score_l     = r_score_l;
    assign score_r     = r_score_r;
    assign game_over   = r_over;
    assign winner      = r_winner;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: directed table, hand sequences and random play
// compared against a frame-counting match model.
// Outputs sampled 1 time unit after each rising edge.
module tb_pong_match_ctrl;

    localparam int WIN = 11;
    localparam int SF  = 60;
    localparam int PF  = 90;
    localparam int HPL = 4;
    localparam int MXS = 3;

    logic       clk50 = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0, start = 1'b0, miss_l = 1'b0, miss_r = 1'b0, hit = 1'b0;
    logic       ball_run, ball_center, serve_dir, game_over, winner;
    logic [1:0] ball_speed;
    logic [7:0] score_l, score_r;

    int n_vec = 0;
    int n_err = 0;

    pong_match_ctrl #(
        .WIN_SCORE(WIN), .SERVE_FRAMES(SF), .POINT_FRAMES(PF),
        .HITS_PER_LEVEL(HPL), .MAX_SPEED(MXS)
    ) dut (
        .clk50(clk50), .reset(reset), .frame_tick(frame_tick), .start(start),
        .miss_l(miss_l), .miss_r(miss_r), .hit(hit),
        .ball_run(ball_run), .ball_center(ball_center), .serve_dir(serve_dir),
        .ball_speed(ball_speed), .score_l(score_l), .score_r(score_r),
        .game_over(game_over), .winner(winner)
    );

    always #5 clk50 = ~clk50;

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 serve, 2 play, 3 point, 4 over; m_left = ticks still owed.
    int m_mode, m_left, m_hits, m_speed, m_sl, m_sr;
    bit m_run, m_ctr, m_dir, m_over, m_win, m_p1, m_p2;

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_hits = 0; m_speed = 1; m_sl = 0; m_sr = 0;
        m_run = 0; m_ctr = 0; m_dir = 0; m_over = 0; m_win = 0; m_p1 = 0; m_p2 = 0;
    endtask

    function automatic logic [7:0] bcd(input int s);
        return 8'(((s / 10) << 4) | (s % 10));
    endfunction

    task automatic model_step(input bit tk, input bit st, input bit ml, input bit mr, input bit h);
        bit evt;
        evt  = m_p1 && !m_p2;
        m_p2 = m_p1;
        m_p1 = st;
        m_ctr = 0;
        case (m_mode)
            0, 4: if (evt) begin
                m_sl = 0; m_sr = 0; m_over = 0; m_speed = 1; m_hits = 0; m_dir = 0;
                m_ctr = 1; m_left = SF; m_mode = 1;
            end
            1: if (tk) begin
                m_left--;
                if (m_left == 0) m_mode = 2;
            end
            2: if (ml || mr) begin
                if (ml) begin m_sr++; m_dir = 1; end
                else    begin m_sl++; m_dir = 0; end
                m_speed = 1; m_hits = 0; m_left = PF; m_mode = 3;
            end else if (h) begin
                m_hits++;
                if (m_hits == HPL) begin
                    m_hits = 0;
                    if (m_speed < MXS) m_speed++;
                end
            end
            3: if (tk) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_sl == WIN || m_sr == WIN) begin
                        m_over = 1; m_win = (m_sr == WIN); m_mode = 4;
                    end else begin
                        m_ctr = 1; m_left = SF; m_mode = 1;
                    end
                end
            end
            default: ;
        endcase
        m_run = (m_mode == 2);
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_model(input string nm);
        logic [31:0] act, exp;
        act = {9'd0, ball_run, ball_center, serve_dir, ball_speed, score_l, score_r,
               game_over, winner & m_over};
        exp = {9'd0, m_run, m_ctr, m_dir, 2'(m_speed), bcd(m_sl), bcd(m_sr),
               m_over, m_win & m_over};
        chk(nm, act, exp);
    endtask

    task automatic cyc(input bit tk, input bit st, input bit ml, input bit mr, input bit h);
        frame_tick = tk; start = st; miss_l = ml; miss_r = mr; hit = h;
        @(posedge clk50);
        model_step(tk, st, ml, mr, h);
        #1;
        chk_model("model");
    endtask

    task automatic play_point(input bit left_miss);
        cyc(0, 0, left_miss, !left_miss, 0);
        repeat (PF) cyc(1, 0, 0, 0, 0);
        if (!m_over) repeat (SF) cyc(1, 0, 0, 0, 0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int         reps;
        logic       tk, st, ml, mr, h;
        logic       run, ctr;
        logic [1:0] spd;
        logic [7:0] sl, sr;
        logic       dir, ovr;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl[NV];

    initial begin
        tbl[0]  = '{1,  0,0,0,0,0, 0,0,2'd1,8'h00,8'h00,0,0};
        tbl[1]  = '{1,  0,1,0,0,0, 0,0,2'd1,8'h00,8'h00,0,0};
        tbl[2]  = '{1,  0,1,0,0,0, 0,1,2'd1,8'h00,8'h00,0,0};
        tbl[3]  = '{1,  0,1,0,0,0, 0,0,2'd1,8'h00,8'h00,0,0};
        tbl[4]  = '{59, 1,0,0,0,0, 0,0,2'd1,8'h00,8'h00,0,0};
        tbl[5]  = '{1,  1,0,0,0,0, 1,0,2'd1,8'h00,8'h00,0,0};
        tbl[6]  = '{3,  0,0,0,0,1, 1,0,2'd1,8'h00,8'h00,0,0};
        tbl[7]  = '{1,  0,0,0,0,1, 1,0,2'd2,8'h00,8'h00,0,0};
        tbl[8]  = '{8,  0,0,0,0,1, 1,0,2'd3,8'h00,8'h00,0,0};
        tbl[9]  = '{4,  0,0,0,0,1, 1,0,2'd3,8'h00,8'h00,0,0};
        tbl[10] = '{1,  0,0,0,1,0, 0,0,2'd1,8'h01,8'h00,0,0};
        tbl[11] = '{89, 1,0,0,0,0, 0,0,2'd1,8'h01,8'h00,0,0};
        tbl[12] = '{1,  1,0,0,0,0, 0,1,2'd1,8'h01,8'h00,0,0};
        tbl[13] = '{60, 1,0,0,0,0, 1,0,2'd1,8'h01,8'h00,0,0};
        tbl[14] = '{1,  0,0,1,1,1, 0,0,2'd1,8'h01,8'h01,1,0};
        tbl[15] = '{90, 1,0,0,0,0, 0,1,2'd1,8'h01,8'h01,1,0};
        tbl[16] = '{60, 1,0,0,0,0, 1,0,2'd1,8'h01,8'h01,1,0};

        model_reset();
        repeat (2) @(posedge clk50);
        #1;
        chk("reset_state",
            {9'd0, ball_run, ball_center, serve_dir, ball_speed, score_l, score_r, game_over, winner},
            {9'd0, 1'b0, 1'b0, 1'b0, 2'd1, 8'h00, 8'h00, 1'b0, 1'b0});
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            for (int r = 0; r < tbl[i].reps; r++) cyc(tbl[i].tk, tbl[i].st, tbl[i].ml, tbl[i].mr, tbl[i].h);
            chk($sformatf("tbl%0d", i),
                {10'd0, ball_run, ball_center, ball_speed, score_l, score_r, serve_dir, game_over},
                {10'd0, tbl[i].run, tbl[i].ctr, tbl[i].spd, tbl[i].sl, tbl[i].sr, tbl[i].dir, tbl[i].ovr});
        end

        // Left player climbs from 1 to 9, then the BCD carry into tens.
        for (int i = 0; i < 8; i++) play_point(1'b0);
        chk("left_at_9", {24'd0, score_l}, 32'h09);
        cyc(0, 0, 0, 1, 0);
        chk("bcd_carry", {24'd0, score_l}, 32'h10);
        repeat (PF + SF) cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        chk("score_11", {24'd0, score_l}, 32'h11);
        repeat (PF - 1) cyc(1, 0, 0, 0, 0);
        chk("over_pending", {31'd0, game_over}, 32'd0);
        cyc(1, 0, 0, 0, 0);
        chk("game_over", {30'd0, game_over, winner}, {30'd0, 1'b1, 1'b0});
        chk("over_no_center", {31'd0, ball_center}, 32'd0);
        cyc(1, 0, 1, 0, 1);
        chk("over_frozen", {16'd0, score_l, score_r}, {16'd0, 8'h11, 8'h01});

        // Restart from OVER clears the match.
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("restart", {15'd0, ball_center, score_l, score_r, game_over},
            {15'd0, 1'b1, 8'h00, 8'h00, 1'b0});
        cyc(0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a POINT pause.
        repeat (SF) cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        repeat (30) cyc(1, 0, 0, 0, 0);
        chk("pre_reset_sr", {24'd0, score_r}, 32'h01);
        reset = 1'b0;
        #1;
        model_reset();
        chk("async_reset",
            {9'd0, ball_run, ball_center, serve_dir, ball_speed, score_l, score_r, game_over, winner},
            {9'd0, 1'b0, 1'b0, 1'b0, 2'd1, 8'h00, 8'h00, 1'b0, 1'b0});
        repeat (2) @(posedge clk50);
        #1;
        reset = 1'b1;
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("post_reset_start", {31'd0, ball_center}, 32'd1);
        cyc(0, 0, 0, 0, 0);

        // Random play against the model.
        for (int i = 0; i < 6000; i++) begin
            cyc(1'($urandom % 2), ($urandom % 100) < 3, ($urandom % 100) < 2,
                ($urandom % 100) < 2, ($urandom % 100) < 15);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
